hash_bits_off_sequencer: RTL

Time-multiplexes one chunk popcount datapath across a full Skein hash so that the bits-off distance to the target costs one popcount tree, not HASH_W/CHUNK_W trees.
- Accepts a hash plus its nonce tag via valid/ready and XORs the hash with the static target.
- Feeds the XOR result CHUNK_W bits per cycle into the popcount sub-block and accumulates the count.
- Reports the count, and tracks the best (lowest) count and its nonce.
- Sits between the Skein round pipeline output and the host/UART result reporter.

---
 rtl/hash_bits_off_pkg.sv | 28 ++
 rtl/hash_bits_off_chunk_count.sv | 47 ++++
 rtl/hash_bits_off_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hash_bits_off_pkg.sv
// Shared definitions for the bits-off sequencer: default widths, count width
// derivation, FSM state type and the 6-bit popcount LUT stage.
//
// Ports: none (package).
package hash_bits_off_pkg;

  localparam int unsigned HashWDefault  = 1024;
  localparam int unsigned ChunkWDefault = 64;
  localparam int unsigned NonceWDefault = 64;

  // Width needed to hold any bit count from 0 to hash_w inclusive.
  function automatic int unsigned cnt_w(input int unsigned hash_w);
    return $clog2(hash_w + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN,
    REPORT
  } seq_state_e;

  // One 6-input LUT stage: ones count of a 6-bit group.
  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]) + 3'(v[5]);
  endfunction

endpackage

// File: rtl/hash_bits_off_chunk_count.sv
// Registered popcount of one ChunkW-bit slice, built from 6-bit LUT stages.
// Latency 1 cycle.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears the output register)
//   chunk_i  slice to count
//   count_o  ones count of chunk_i from the previous cycle
module hash_bits_off_chunk_count
  import hash_bits_off_pkg::*;
#(
  parameter int unsigned ChunkW = ChunkWDefault
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ChunkW-1:0]            chunk_i,
  output logic [$clog2(ChunkW+1)-1:0]  count_o
);

  localparam int unsigned CcW       = $clog2(ChunkW + 1);
  localparam int unsigned NumGroups = (ChunkW + 5) / 6;

  logic [NumGroups*6-1:0] w_padded;
  logic [CcW-1:0]         w_sum;
  logic [CcW-1:0]         r_count;

  // Zero-pad the slice to a whole number of 6-bit groups, then sum the groups.
  always_comb begin
    w_padded               = '0;
    w_padded[ChunkW-1:0]   = chunk_i;
    w_sum                  = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      w_sum = w_sum + CcW'(popcnt6(w_padded[g*6 +: 6]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_sum;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/hash_bits_off_sequencer.sv
// Scores a hash by its Hamming distance ("bits off") to a static target,
// reusing one ChunkW-bit popcount stage over HashW/ChunkW cycles, and tracks
// the lowest score seen together with its nonce.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   target_i                target hash, static while busy
//   threshold_i             hit threshold (hit when count <= threshold)
//   clear_best_i            pulse: forget the best result
//   in_valid_i/in_ready_o   hash offer handshake; hash_i, nonce_i payload
//   out_valid_o/out_ready_i result handshake; count_o, nonce_o, hit_o payload
//   best_valid_o            best_count_o/best_nonce_o are meaningful
//   best_count_o/nonce_o    lowest count since reset/clear and its nonce
module hash_bits_off_sequencer
  import hash_bits_off_pkg::*;
#(
  parameter  int unsigned HashW  = HashWDefault,
  parameter  int unsigned ChunkW = ChunkWDefault,
  parameter  int unsigned NonceW = NonceWDefault,
  localparam int unsigned CntW   = cnt_w(HashW)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [HashW-1:0]  target_i,
  input  logic [CntW-1:0]   threshold_i,
  input  logic              clear_best_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [HashW-1:0]  hash_i,
  input  logic [NonceW-1:0] nonce_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CntW-1:0]   count_o,
  output logic [NonceW-1:0] nonce_o,
  output logic              hit_o,
  output logic              best_valid_o,
  output logic [CntW-1:0]   best_count_o,
  output logic [NonceW-1:0] best_nonce_o
);

  localparam int unsigned     NumChunks = HashW / ChunkW;
  localparam int unsigned     IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned     CcW       = $clog2(ChunkW + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumChunks - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_next;
  logic [HashW-1:0]  r_diff;
  logic [NonceW-1:0] r_nonce;
  logic [IdxW-1:0]   r_idx;
  logic [CntW-1:0]   r_acc;
  logic              r_cnt_vld;
  logic              r_out_valid;
  logic [CntW-1:0]   r_count;
  logic [NonceW-1:0] r_nonce_out;
  logic              r_hit;
  logic              r_best_valid;
  logic [CntW-1:0]   r_best_count;
  logic [NonceW-1:0] r_best_nonce;

  logic [ChunkW-1:0] w_chunk;
  logic [CcW-1:0]    w_chunk_cnt;
  logic [CntW-1:0]   w_total;
  logic              w_in_fire;
  logic              w_better;

  assign in_ready_o = (r_state == IDLE);
  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_chunk    = r_diff[r_idx*ChunkW +: ChunkW];

  hash_bits_off_chunk_count #(
    .ChunkW (ChunkW)
  ) u_chunk_count (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .chunk_i (w_chunk),
    .count_o (w_chunk_cnt)
  );

  // Accumulator plus the count returning this cycle; in DRAIN this is the final score.
  assign w_total = r_acc + CntW'(w_chunk_cnt);

  // A coincident clear wipes the old best first, so the new result always wins.
  assign w_better = clear_best_i || !r_best_valid || (w_total < r_best_count);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_in_fire) w_state_next = COUNT;
      COUNT:   if (r_idx == LastIdx) w_state_next = DRAIN;
      DRAIN:   w_state_next = REPORT;
      REPORT:  if (out_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_diff       <= '0;
      r_nonce      <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_cnt_vld    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_count      <= '0;
      r_nonce_out  <= '0;
      r_hit        <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_count <= CntW'(HashW);
      r_best_nonce <= '0;
    end else begin
      // The popcount stage answers one cycle after a chunk is issued in COUNT.
      r_cnt_vld <= (r_state == COUNT);
      if (r_cnt_vld) begin
        r_acc <= w_total;
      end

      if (w_in_fire) begin
        r_diff  <= hash_i ^ target_i;
        r_nonce <= nonce_i;
        r_acc   <= '0;
        r_idx   <= '0;
      end

      if (r_state == COUNT) begin
        r_idx <= r_idx + IdxW'(1);
      end

      if (clear_best_i) begin
        r_best_valid <= 1'b0;
        r_best_count <= CntW'(HashW);
      end

      if (r_state == DRAIN) begin
        r_out_valid <= 1'b1;
        r_count     <= w_total;
        r_nonce_out <= r_nonce;
        r_hit       <= (w_total <= threshold_i);
        if (w_better) begin
          r_best_valid <= 1'b1;
          r_best_count <= w_total;
          r_best_nonce <= r_nonce;
        end
      end else if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign count_o      = r_count;
  assign nonce_o      = r_nonce_out;
  assign hit_o        = r_hit;
  assign best_valid_o = r_best_valid;
  assign best_count_o = r_best_count;
  assign best_nonce_o = r_best_nonce;

endmodule
